ls_sequencer: RTL

Multi-cycle load/store sequencer between the core's execute stage and the data-memory port. It accepts one memory operation at a time over a valid/ready handshake and drives a request/grant/rvalid data bus. Accesses that cross a word boundary are split into two aligned bus transactions. Returned load data is aligned, sign- or zero-extended, and handed back to writeback as a single-cycle response.

---
 rtl/ls_sequencer_pkg.sv | 59 +++++
 rtl/ls_sequencer_align.sv | 45 ++++
 rtl/ls_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ls_sequencer_pkg.sv
// Shared types and decode helpers for the load/store sequencer.
// ls_op_t carries the full execute-stage op set so non-memory ops can be flagged.
package ls_sequencer_pkg;

    typedef enum logic [3:0] {
        i_NOP = 4'd0,
        i_LB  = 4'd1,
        i_LH  = 4'd2,
        i_LW  = 4'd3,
        i_LBU = 4'd4,
        i_LHU = 4'd5,
        i_SB  = 4'd6,
        i_SH  = 4'd7,
        i_SW  = 4'd8,
        i_ALU = 4'd9
    } ls_op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_WAIT0,
        S_ISSUE1,
        S_WAIT1,
        S_RESP
    } seq_state_t;

    function automatic logic is_mem_op(input ls_op_t op);
        case (op)
            i_LB, i_LH, i_LW, i_LBU, i_LHU, i_SB, i_SH, i_SW: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input ls_op_t op);
        case (op)
            i_SB, i_SH, i_SW: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] access_mask(input ls_op_t op);
        case (op)
            i_LB, i_LBU, i_SB: return 8'h01;
            i_LH, i_LHU, i_SH: return 8'h03;
            i_LW, i_SW:        return 8'h0F;
            default:           return 8'h00;
        endcase
    endfunction

    // Byte lanes touched across two consecutive words; bits [7:4] belong to the upper word.
    function automatic logic [7:0] lane_vector(input ls_op_t op, input logic [1:0] off);
        return access_mask(op) << off;
    endfunction

    function automatic logic spans_word(input ls_op_t op, input logic [1:0] off);
        return lane_vector(op, off) > 8'h0F;
    endfunction

endpackage

// File: rtl/ls_sequencer_align.sv
// Combinational lane generation, store-data shifting and load extraction/extension.
// Purely a function of the sequencer's latched registers.
module ls_align
    import ls_sequencer_pkg::*;
(
    input  ls_op_t      op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wr_lo,
    output logic [31:0] wr_hi,
    output logic        spans,
    output logic [31:0] load_data
);

    logic [7:0]  lanes;
    logic [63:0] shifted_w;
    logic [31:0] raw;
    logic [4:0]  bit_shift;

    always_comb begin
        bit_shift = {off, 3'b000};
        lanes     = lane_vector(op, off);
        be_lo     = lanes[3:0];
        be_hi     = lanes[7:4];
        spans     = |lanes[7:4];
        shifted_w = {32'h0, wdata} << bit_shift;
        wr_lo     = shifted_w[31:0];
        wr_hi     = shifted_w[63:32];
        // Only the low word of the shifted pair is the load result.
        raw       = 32'({hi, lo} >> bit_shift);
        case (op)
            i_LB:    load_data = {{24{raw[7]}}, raw[7:0]};
            i_LBU:   load_data = {24'h0, raw[7:0]};
            i_LH:    load_data = {{16{raw[15]}}, raw[15:0]};
            i_LHU:   load_data = {16'h0, raw[15:0]};
            i_LW:    load_data = raw;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/ls_sequencer.sv
// Load/store sequencer: accepts one memory op, runs one or two aligned bus
// transactions on the data port, then returns a single-cycle response.
module ls_sequencer
    import ls_sequencer_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  ls_op_t      req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_fault,
    output logic        d_req,
    input  logic        d_gnt,
    output logic        d_we,
    output logic [31:0] d_addr,
    output logic [3:0]  d_be,
    output logic [31:0] d_wr_data,
    input  logic        d_rvalid,
    input  logic [31:0] d_rd_data
);

    seq_state_t  state_q;
    seq_state_t  state_d;
    ls_op_t      op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic [4:0]  rd_q;
    logic        fault_q;

    logic        accept;
    logic        req_fault;
    logic [31:0] base_addr;
    logic [3:0]  be_lo;
    logic [3:0]  be_hi;
    logic [31:0] wr_lo;
    logic [31:0] wr_hi;
    logic        spans;
    logic [31:0] load_data;

    assign accept    = req_valid && (state_q == S_IDLE);
    // Without splitting, only word-crossing accesses are unserviceable.
    assign req_fault = !is_mem_op(req_op) ||
                       (!SPLIT_MISALIGNED && spans_word(req_op, req_addr[1:0]));
    assign base_addr = {addr_q[31:2], 2'b00};

    ls_align u_align (
        .op        (op_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .lo        (lo_q),
        .hi        (hi_q),
        .be_lo     (be_lo),
        .be_hi     (be_hi),
        .wr_lo     (wr_lo),
        .wr_hi     (wr_hi),
        .spans     (spans),
        .load_data (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= i_NOP;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rd_q    <= 5'h0;
            fault_q <= 1'b0;
            lo_q    <= 32'h0;
            hi_q    <= 32'h0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
                fault_q <= req_fault;
                lo_q    <= 32'h0;
                hi_q    <= 32'h0;
            end
            if ((state_q == S_WAIT0) && d_rvalid) begin
                lo_q <= d_rd_data;
            end
            if ((state_q == S_WAIT1) && d_rvalid) begin
                hi_q <= d_rd_data;
            end
        end
    end

    // Every output decodes from state and latched registers only.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_fault = 1'b0;
        resp_data  = 32'h0;
        resp_rd    = 5'h0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_be       = 4'h0;
        d_addr     = 32'h0;
        d_wr_data  = 32'h0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_fault ? S_RESP : S_ISSUE0;
                end
            end
            S_ISSUE0: begin
                d_req     = 1'b1;
                d_we      = is_store(op_q);
                d_addr    = base_addr;
                d_be      = be_lo;
                d_wr_data = wr_lo;
                if (d_gnt) begin
                    state_d = S_WAIT0;
                end
            end
            S_WAIT0: begin
                if (d_rvalid) begin
                    state_d = spans ? S_ISSUE1 : S_RESP;
                end
            end
            S_ISSUE1: begin
                d_req     = 1'b1;
                d_we      = is_store(op_q);
                d_addr    = base_addr + 32'd4;
                d_be      = be_hi;
                d_wr_data = wr_hi;
                if (d_gnt) begin
                    state_d = S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (d_rvalid) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                resp_rd    = rd_q;
                resp_data  = fault_q ? 32'h0 : load_data;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
